// File: rtl/draw_engine.sv
// draw_engine: rasterises bricks, paddle and ball into 160x120 plot writes, one pixel per cycle.
// Optional `PIXEL_STALL_EN adds a pix_ready input that stalls the pixel walk while low.
module draw_engine #(
    parameter int unsigned BRICK_W     = 24,
    parameter int unsigned BRICK_H     = 6,
    parameter int unsigned BRICK_GAP   = 2,
    parameter int unsigned BRICK_X0    = 2,
    parameter int unsigned BRICK_Y0    = 10,
    parameter int unsigned PADDLE_W    = 20,
    parameter int unsigned PADDLE_H    = 2,
    parameter int unsigned PADDLE_Y    = 110,
    parameter int unsigned BALL_SIZE   = 2,
    parameter logic [2:0]  ROW0_COLOUR = 3'b100,
    parameter logic [2:0]  ROW1_COLOUR = 3'b010,
    parameter logic [2:0]  FG_COLOUR   = 3'b111
) (
    input  logic        clk,
    input  logic        resetn,
`ifdef PIXEL_STALL_EN
    input  logic        pix_ready,
`endif
    input  logic [4:0]  ld_draw,
    input  logic [7:0]  paddle_x,
    input  logic [7:0]  ball_x,
    input  logic [6:0]  ball_y,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic [4:0]  active_code,
    output logic [11:0] brick_alive
);

    localparam logic [4:0] CODE_PADDLE_DRAW  = 5'd13;
    localparam logic [4:0] CODE_PADDLE_ERASE = 5'd14;
    localparam logic [4:0] CODE_BALL_DRAW    = 5'd15;
    localparam logic [4:0] CODE_BALL_ERASE   = 5'd16;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_ox;
    logic [6:0]  r_oy;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [7:0]  r_w;
    logic [6:0]  r_h;
    logic [2:0]  r_colour;
    logic [4:0]  r_code;
    logic [3:0]  r_brick_idx;
    logic [4:0]  r_last_code;
    logic        r_armed;
    logic [7:0]  r_paddle_x;
    logic [7:0]  r_ball_x;
    logic [6:0]  r_ball_y;
    logic [11:0] r_brick_alive;

    logic        w_is_populate;
    logic        w_is_remove;
    logic        w_valid;
    logic        w_accept;
    logic        w_step;
    logic        w_last_col;
    logic        w_last_pixel;
    logic        w_final_step;
    logic        w_clip;
    logic [4:0]  w_brick_idx;
    logic        w_brick_row;
    logic [4:0]  w_brick_col;
    logic [7:0]  w_org_x;
    logic [6:0]  w_org_y;
    logic [7:0]  w_size_w;
    logic [6:0]  w_size_h;
    logic [2:0]  w_colour;
    logic [8:0]  w_px;
    logic [8:0]  w_py;

    assign w_is_populate = (ld_draw >= 5'd1)  && (ld_draw <= 5'd12);
    assign w_is_remove   = (ld_draw >= 5'd17) && (ld_draw <= 5'd28);
    assign w_valid       = (ld_draw != 5'd0)  && (ld_draw <= 5'd28);
    assign w_brick_idx   = w_is_populate ? ld_draw - 5'd1 : ld_draw - 5'd17;
    assign w_brick_row   = (w_brick_idx >= 5'd6);
    assign w_brick_col   = w_brick_row ? w_brick_idx - 5'd6 : w_brick_idx;

    // Geometry and colour of the command presented on ld_draw, latched only on accept.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_org_x  = '0;
        w_org_y  = '0;
        w_size_w = '0;
        w_size_h = '0;
        w_colour = '0;
        if (w_is_populate || w_is_remove) begin
            w_org_x  = 8'(BRICK_X0 + 32'(w_brick_col) * (BRICK_W + BRICK_GAP));
            w_org_y  = 7'(BRICK_Y0 + (w_brick_row ? (BRICK_H + BRICK_GAP) : 32'd0));
            w_size_w = 8'(BRICK_W);
            w_size_h = 7'(BRICK_H);
            w_colour = w_is_remove ? 3'b000 : (w_brick_row ? ROW1_COLOUR : ROW0_COLOUR);
        end else begin
            case (ld_draw)
                CODE_PADDLE_DRAW, CODE_PADDLE_ERASE: begin
                    w_org_x  = (ld_draw == CODE_PADDLE_DRAW) ? paddle_x : r_paddle_x;
                    w_org_y  = 7'(PADDLE_Y);
                    w_size_w = 8'(PADDLE_W);
                    w_size_h = 7'(PADDLE_H);
                    w_colour = (ld_draw == CODE_PADDLE_DRAW) ? FG_COLOUR : 3'b000;
                end
                CODE_BALL_DRAW, CODE_BALL_ERASE: begin
                    w_org_x  = (ld_draw == CODE_BALL_DRAW) ? ball_x : r_ball_x;
                    w_org_y  = (ld_draw == CODE_BALL_DRAW) ? ball_y : r_ball_y;
                    w_size_w = 8'(BALL_SIZE);
                    w_size_h = 7'(BALL_SIZE);
                    w_colour = (ld_draw == CODE_BALL_DRAW) ? FG_COLOUR : 3'b000;
                end
                default: ;
            endcase
        end
    end

`ifdef PIXEL_STALL_EN
    assign w_step = pix_ready;
`else
    assign w_step = 1'b1;
`endif

    // Sums kept at 9 bits so off-screen pixels are detected before truncation.
    assign w_px         = {1'b0, r_ox} + {1'b0, r_cx};
    assign w_py         = {2'b00, r_oy} + {2'b00, r_cy};
    assign w_clip       = (w_px >= 9'd160) || (w_py >= 9'd120);
    assign w_last_col   = (r_cx == r_w - 8'd1);
    assign w_last_pixel = w_last_col && (r_cy == r_h - 7'd1);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_final_step = 1'b0;
        busy         = 1'b0;
        plot         = 1'b0;
        x            = '0;
        y            = '0;
        colour       = '0;
        active_code  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_valid && (r_armed || (ld_draw != r_last_code))) begin
                    w_accept     = 1'b1;
                    busy         = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                x            = w_px[7:0];
                y            = w_py[6:0];
                colour       = r_colour;
                active_code  = r_code;
                plot         = w_step && !w_clip;
                w_final_step = w_step && w_last_pixel;
                // busy drops on the final pixel so the controller can advance in step.
                busy         = !w_final_step;
                if (w_final_step) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ox          <= '0;
            r_oy          <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_w           <= '0;
            r_h           <= '0;
            r_colour      <= '0;
            r_code        <= '0;
            r_brick_idx   <= '0;
            r_last_code   <= '0;
            r_armed       <= 1'b1;
            r_paddle_x    <= '0;
            r_ball_x      <= '0;
            r_ball_y      <= '0;
            r_brick_alive <= '0;
        end else begin
            if ((r_state == S_IDLE) && (ld_draw != r_last_code)) begin
                r_armed <= 1'b1;
            end
            if (w_accept) begin
                r_ox        <= w_org_x;
                r_oy        <= w_org_y;
                r_w         <= w_size_w;
                r_h         <= w_size_h;
                r_colour    <= w_colour;
                r_code      <= ld_draw;
                r_brick_idx <= w_brick_idx[3:0];
                r_cx        <= '0;
                r_cy        <= '0;
            end else if ((r_state == S_RUN) && w_step) begin
                if (w_last_pixel) begin
                    // A held code must not retrigger, so completion disarms until ld_draw changes.
                    r_last_code <= r_code;
                    r_armed     <= 1'b0;
                    if ((r_code >= 5'd1) && (r_code <= 5'd12)) begin
                        r_brick_alive[r_brick_idx] <= 1'b1;
                    end else if ((r_code >= 5'd17) && (r_code <= 5'd28)) begin
                        r_brick_alive[r_brick_idx] <= 1'b0;
                    end else if (r_code == CODE_PADDLE_DRAW) begin
                        r_paddle_x <= r_ox;
                    end else if (r_code == CODE_BALL_DRAW) begin
                        r_ball_x <= r_ox;
                        r_ball_y <= r_oy;
                    end
                end else if (w_last_col) begin
                    r_cx <= '0;
                    r_cy <= r_cy + 7'd1;
                end else begin
                    r_cx <= r_cx + 8'd1;
                end
            end
        end
    end

    assign brick_alive = r_brick_alive;

endmodule

// File: tb/tb_draw_engine.sv
// tb_draw_engine: table-driven directed commands, randomized commands against a behavioural
// model of the drawing rules, and a mid-run reset sequence.
module tb_draw_engine;

    logic        clk;
    logic        resetn;
    logic [4:0]  ld_draw;
    logic [7:0]  paddle_x;
    logic [7:0]  ball_x;
    logic [6:0]  ball_y;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic [4:0]  active_code;
    logic [11:0] brick_alive;
`ifdef PIXEL_STALL_EN
    logic        pix_ready = 1'b1;
`endif

    draw_engine dut (
        .clk         (clk),
        .resetn      (resetn),
`ifdef PIXEL_STALL_EN
        .pix_ready   (pix_ready),
`endif
        .ld_draw     (ld_draw),
        .paddle_x    (paddle_x),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .active_code (active_code),
        .brick_alive (brick_alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    bit [11:0] m_alive;
    int        m_last;
    bit        m_armed;
    int        m_px;
    int        m_bx;
    int        m_by;

    typedef struct {
        int          code;
        int          px;
        int          bx;
        int          by;
        int          run_ld;
        int          reps;
        bit          acc;
        int          ox;
        int          oy;
        int          w;
        int          h;
        int          col;
        logic [11:0] alive;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_alive = '0;
        m_last  = 0;
        m_armed = 1'b1;
        m_px    = 0;
        m_bx    = 0;
        m_by    = 0;
    endtask

    function automatic void model_expect(input int code, input int px, input int bx, input int by,
                                         output bit acc, output int ox, output int oy,
                                         output int w, output int h, output int col);
        int n;
        int r;
        int c;
        acc = (code >= 1) && (code <= 28) && (m_armed || (code != m_last));
        ox = 0; oy = 0; w = 0; h = 0; col = 0;
        if ((code >= 1 && code <= 12) || (code >= 17 && code <= 28)) begin
            n   = (code <= 12) ? code : code - 16;
            r   = (n - 1) / 6;
            c   = (n - 1) % 6;
            ox  = 2 + c * 26;
            oy  = 10 + r * 8;
            w   = 24;
            h   = 6;
            col = (code <= 12) ? ((r == 0) ? 4 : 2) : 0;
        end else if (code == 13 || code == 14) begin
            ox  = (code == 13) ? px : m_px;
            oy  = 110;
            w   = 20;
            h   = 2;
            col = (code == 13) ? 7 : 0;
        end else if (code == 15 || code == 16) begin
            ox  = (code == 15) ? bx : m_bx;
            oy  = (code == 15) ? by : m_by;
            w   = 2;
            h   = 2;
            col = (code == 15) ? 7 : 0;
        end
    endfunction

    // One idle/accept cycle; when accepted, walks every pixel and commits the model.
    task automatic do_cmd(input int code, input int px, input int bx, input int by, input int run_ld,
                          input bit acc, input int ox, input int oy, input int w, input int h,
                          input int col);
        int cx;
        int cy;
        int xx;
        int yy;
        bit pl;
        bit last;
        ld_draw  = 5'(code);
        paddle_x = 8'(px);
        ball_x   = 8'(bx);
        ball_y   = 7'(by);
        @(negedge clk);
        check($sformatf("accept code%0d", code), {busy, plot, active_code}, {acc, 1'b0, 5'd0});
        if (code != m_last) m_armed = 1'b1;
        @(posedge clk);
        #1;
        if (!acc) return;
        ld_draw = 5'(run_ld);
        for (int k = 0; k < w * h; k++) begin
            cx   = k % w;
            cy   = k / w;
            xx   = ox + cx;
            yy   = oy + cy;
            pl   = (xx < 160) && (yy < 120);
            last = (k == w * h - 1);
            @(negedge clk);
            check($sformatf("pixel%0d code%0d", k, code),
                  {x, y, colour, plot, busy, active_code},
                  {8'(xx), 7'(yy), 3'(col), pl, !last, 5'(code)});
            @(posedge clk);
            #1;
        end
        m_last  = code;
        m_armed = 1'b0;
        if (code >= 1 && code <= 12) m_alive[code - 1] = 1'b1;
        else if (code >= 17 && code <= 28) m_alive[code - 17] = 1'b0;
        else if (code == 13) m_px = ox;
        else if (code == 15) begin
            m_bx = ox;
            m_by = oy;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int ox, oy, w, h, col;
        int code, px, bx, by;

        //        code  px  bx  by run reps acc  ox   oy   w  h col  alive
        tbl[0]  = '{1,   0,  0,  0,  1,  1, 1,   2,  10, 24, 6, 4, 12'h001};
        tbl[1]  = '{1,   0,  0,  0,  1,  3, 0,   0,   0,  0, 0, 0, 12'h001};
        tbl[2]  = '{13, 70,  0,  0,  0,  1, 1,  70, 110, 20, 2, 7, 12'h001};
        tbl[3]  = '{0,  80,  0,  0,  0,  1, 0,   0,   0,  0, 0, 0, 12'h001};
        tbl[4]  = '{14, 80,  0,  0,  0,  1, 1,  70, 110, 20, 2, 0, 12'h001};
        tbl[5]  = '{12,  0,  0,  0,  0,  1, 1, 132,  18, 24, 6, 2, 12'h801};
        tbl[6]  = '{28,  0,  0,  0,  0,  1, 1, 132,  18, 24, 6, 0, 12'h001};
        tbl[7]  = '{30,  0,  0,  0,  0, 10, 0,   0,   0,  0, 0, 0, 12'h001};
        tbl[8]  = '{15,  0, 50, 60,  0,  1, 1,  50,  60,  2, 2, 7, 12'h001};
        tbl[9]  = '{16,  0,  0,  0, 16,  1, 1,  50,  60,  2, 2, 0, 12'h001};
        tbl[10] = '{13,150,  0,  0, 13,  1, 1, 150, 110, 20, 2, 7, 12'h001};
        tbl[11] = '{14,  0,  0,  0,  0,  1, 1, 150, 110, 20, 2, 0, 12'h001};
        tbl[12] = '{7,   0,  0,  0,  0,  1, 1,   2,  18, 24, 6, 2, 12'h041};

        resetn   = 1'b0;
        ld_draw  = '0;
        paddle_x = '0;
        ball_x   = '0;
        ball_y   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_outputs", {busy, plot, x, y, colour, active_code}, '0);
        check("reset_alive", 32'(brick_alive), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                do_cmd(tbl[i].code, tbl[i].px, tbl[i].bx, tbl[i].by, tbl[i].run_ld,
                       tbl[i].acc, tbl[i].ox, tbl[i].oy, tbl[i].w, tbl[i].h, tbl[i].col);
            end
            check($sformatf("tbl%0d_alive", i), 32'(brick_alive), 32'(tbl[i].alive));
        end

        // Same code re-accepted once ld_draw has left it for a cycle.
        model_expect(0, 0, 0, 0, acc, ox, oy, w, h, col);
        do_cmd(0, 0, 0, 0, 0, acc, ox, oy, w, h, col);
        model_expect(7, 0, 0, 0, acc, ox, oy, w, h, col);
        do_cmd(7, 0, 0, 0, 0, acc, ox, oy, w, h, col);
        check("rearm_alive", 32'(brick_alive), 32'(m_alive));

        for (int i = 0; i < 40; i++) begin
            code = int'($urandom_range(0, 31));
            px   = int'($urandom_range(0, 255));
            bx   = int'($urandom_range(0, 255));
            by   = int'($urandom_range(0, 127));
            model_expect(code, px, bx, by, acc, ox, oy, w, h, col);
            do_cmd(code, px, bx, by, int'($urandom_range(0, 31)), acc, ox, oy, w, h, col);
            check($sformatf("rand%0d_alive", i), 32'(brick_alive), 32'(m_alive));
        end

        // Reset during brick 3 after 50 pixels.
        ld_draw = 5'd3;
        @(negedge clk);
        check("midreset_accept", {busy, plot, active_code}, {1'b1, 1'b0, 5'd0});
        @(posedge clk);
        #1 ld_draw = 5'd0;
        repeat (50) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        @(negedge clk);
        check("midreset_outputs", {busy, plot, active_code}, '0);
        check("midreset_alive", 32'(brick_alive), 32'd0);
        @(posedge clk);
        #1;
        model_expect(3, 0, 0, 0, acc, ox, oy, w, h, col);
        do_cmd(3, 0, 0, 0, 3, acc, ox, oy, w, h, col);
        check("after_reset_alive", 32'(brick_alive), 32'h004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/draw_engine.md
Name: draw_engine

Overview:
Pixel-drawing datapath that answers the game controller's ld_draw commands. It rasterises bricks, the paddle and the ball into VGA-adapter plot writes (160x120, 3-bit colour), one pixel per cycle. It returns a combinational busy handshake that the controller uses to hold in its draw/erase/populate/remove states. It also records the last-drawn paddle and ball positions for erasure and keeps the brick-alive map used by collision logic.

Parameters:
BRICK_W, 24, brick width in pixels
BRICK_H, 6, brick height in pixels
BRICK_GAP, 2, gap between bricks, both axes
BRICK_X0, 2, x of column 0
BRICK_Y0, 10, y of row 0
PADDLE_W, 20, paddle width
PADDLE_H, 2, paddle height
PADDLE_Y, 110, fixed paddle top row
BALL_SIZE, 2, ball edge length (square)
ROW0_COLOUR, 3'b100, colour of bricks 1-6
ROW1_COLOUR, 3'b010, colour of bricks 7-12
FG_COLOUR, 3'b111, paddle and ball colour

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ld_draw  in  5  command: 0 idle; 1-12 populate brick n; 13 draw paddle; 14 erase paddle; 15 draw ball; 16 erase ball; 17-28 remove brick n-16; 29-31 invalid
paddle_x  in  8  paddle left x, sampled at accept
ball_x  in  8  ball left x, sampled at accept
ball_y  in  7  ball top y, sampled at accept
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour
plot  out  1  write strobe
busy  out  1  command in progress
active_code  out  5  code being executed; 0 when idle
brick_alive  out  12  bit n-1 set while brick n is on screen

Behaviour:
- Reset is synchronous on the clk edge with resetn=0, and overrides any operation in progress, including mid-run. Reset values: state IDLE, plot 0, busy 0, x/y/colour 0, active_code 0, brick_alive 0, armed 1, last_code 0, recorded paddle x 0, recorded ball x/y 0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - A command is accepted when ld_draw is in 1-28 and (armed=1 or ld_draw != last_code).
  - In the accept cycle busy=1 combinationally, with plot=0. It latches the origin, width, height, colour and code, clears cx/cy, and moves to RUN.
  - Otherwise busy=0 and plot=0.
- Origins:
  - Brick n: row r=(n-1)/6, column c=(n-1)%6; x=BRICK_X0+c*(BRICK_W+BRICK_GAP), y=BRICK_Y0+r*(BRICK_H+BRICK_GAP).
  - Draw paddle: (paddle_x, PADDLE_Y). Erase paddle: recorded paddle x.
  - Draw ball: (ball_x, ball_y). Erase ball: recorded ball x/y.
- Colours: populate uses the row colour; draw paddle/ball use FG_COLOUR; erase and remove use 3'b000.
- RUN:
  - Each cycle drives x=ox+cx, y=oy+cy, with cx stepping fastest.
  - plot=1 unless x>=160 or y>=120 (clipped). A clipped pixel still consumes its cycle.
  - busy=1 on every RUN cycle except the final pixel (cx=W-1, cy=H-1), where busy=0.
  - The cycle after the final pixel, state returns to IDLE with last_code=code and armed=0.
  - Total cycles = W*H+1; a brick takes 145.
- Arithmetic: origin plus counter is computed at 9 bits, then compared against 160/120 for clipping; x and y are truncated to 8/7 bits.
- Side effects, applied on the final pixel:
  - Populate sets brick_alive[n-1]; remove clears it.
  - Draw paddle updates the recorded paddle x; draw ball updates the recorded ball x/y.
- ld_draw is ignored during RUN; changes mid-run do not abort.
- Re-arm: armed is set on any IDLE cycle where ld_draw != last_code, so a held code never restarts.
- Invalid codes (29-31) and 0: no accept, busy=0, plot=0.
- The top level derives per-state handshakes as busy & (active_code==N), plus the accept-cycle term busy & (ld_draw==N).

Optional Feature:
PIXEL_STALL_EN:
- Defined: adds input pix_ready (1 bit). In RUN, when pix_ready=0 the counters and outputs hold, plot is forced to 0 and busy stays 1. The final pixel completes only when pix_ready=1.
- Undefined: no port, and the engine advances every cycle.

Test Plan:
- Reset, then hold ld_draw=1 -> busy=1 in the accept cycle; 144 plots over x 2..25, y 10..15, colour 3'b100; busy=0 on the 144th plot; then brick_alive=12'h001, with no restart while ld_draw=1 is held.
- ld_draw=13 with paddle_x=70, then ld_draw=0, paddle_x=80, ld_draw=14 -> 40 plots at x 70..89, y 110..111, colour 7; then 40 plots at the same coordinates with colour 0.
- Populate brick 12 then ld_draw=28 -> plots with origin (132,18), colour 0; brick_alive[11] clears on the final pixel.
- ld_draw=30 for 10 cycles -> busy=0, plot=0, active_code=0 throughout.
- Reset asserted after 50 pixels of brick 3 -> next cycle plot=0, busy=0, brick_alive=0; ld_draw=3 is then re-accepted.
- ld_draw=13 with paddle_x=150 -> pixels with x 160..169 have plot=0; total duration is still 41 cycles.
